// File: rtl/load_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : load_unit_ctrl
// Purpose  : Runs one decoded load (LB/LH/LW/LBU/LHU) at a time. It computes
//            the effective address and checks it, makes a req/gnt read on
//            the data-memory port and waits for the response. It then
//            extracts and extends the addressed byte or halfword and sends a
//            one-cycle register-file writeback or a one-cycle error strobe.
// Ports    : clk, rst_n                    clock, sync active-low reset
//            ld_valid/ld_ready             load handshake from the decoder
//            ld_control, rs1_data, imm, rd load type, base, offset, dest reg
//            mem_req/mem_addr/mem_gnt      read request channel
//            mem_rvalid/mem_rdata          read response channel
//            wb_valid/wb_rd/wb_data        register-file writeback
//            ld_err/ld_err_cause           error strobe and sticky cause
//            busy                          controller is not idle
// Revision : 1.0 - initial release
// ============================================================================
module load_unit_ctrl #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [2:0]      ld_control,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [11:0]     imm,
   input  logic [4:0]      rd,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            ld_err,
   output logic [1:0]      ld_err_cause,
   output logic            busy
);

   // Load-control codes shared with the decoder; 3'b110/3'b111 are unmapped.
   localparam logic [2:0] LD_NOP = 3'b000;
   localparam logic [2:0] LB     = 3'b001;
   localparam logic [2:0] LH     = 3'b010;
   localparam logic [2:0] LW     = 3'b011;
   localparam logic [2:0] LBU    = 3'b100;
   localparam logic [2:0] LHU    = 3'b101;

   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

   // The last cycle that may still accept a response before the timeout fires.
   localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_WB   = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [XLEN-1:0]   r_addr;
   logic [2:0]        r_type;
   logic [4:0]        r_rd;
   logic [7:0]        r_cnt;
   logic [4:0]        r_wb_rd;
   logic [XLEN-1:0]   r_wb_data;
   logic [1:0]        r_cause;

   logic [XLEN-1:0]   w_eff;
   logic              w_type_ok;
   logic              w_misalign;
   logic              w_accept;
   logic              w_in_flight;
   logic              w_timeout;
   logic              w_capture;
   logic [XLEN-1:0]   w_byte_sh;
   logic [XLEN-1:0]   w_half_sh;
   logic [XLEN-1:0]   w_extract;

   assign w_eff = rs1_data + {{(XLEN-12){imm[11]}}, imm};

   always_comb begin
      w_type_ok = 1'b0;
      case (ld_control)
         LB, LH, LW, LBU, LHU: w_type_ok = 1'b1;
         default:             w_type_ok = 1'b0;
      endcase
   end

   assign w_misalign = (((ld_control == LH) || (ld_control == LHU)) && w_eff[0]) ||
                       ((ld_control == LW) && (w_eff[1:0] != 2'b00));

   assign w_accept    = (r_state == S_IDLE) && ld_valid;
   assign w_in_flight = (r_state == S_REQ) || (r_state == S_WAIT);
   assign w_timeout   = (r_cnt == C_TO_LAST);
   // A response in REQ only counts when it arrives together with the grant.
   assign w_capture   = ((r_state == S_REQ) && mem_gnt && mem_rvalid) ||
                        ((r_state == S_WAIT) && mem_rvalid);

   // Little-endian lane select: shift the addressed lane down to bit 0.
   assign w_byte_sh = mem_rdata >> {r_addr[1:0], 3'b000};
   assign w_half_sh = mem_rdata >> {r_addr[1], 4'b0000};

   always_comb begin
      w_extract = mem_rdata;
      case (r_type)
         LB:      w_extract = {{(XLEN-8){w_byte_sh[7]}}, w_byte_sh[7:0]};
         LBU:     w_extract = {{(XLEN-8){1'b0}}, w_byte_sh[7:0]};
         LH:      w_extract = {{(XLEN-16){w_half_sh[15]}}, w_half_sh[15:0]};
         LHU:     w_extract = {{(XLEN-16){1'b0}}, w_half_sh[15:0]};
         default: w_extract = mem_rdata;
      endcase
   end

   // Next-state logic. A response wins over a timeout that lands in the same cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (ld_valid) begin
               if (!w_type_ok || w_misalign) w_next = S_ERR;
               else                          w_next = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_gnt && mem_rvalid) w_next = S_WB;
            else if (w_timeout)        w_next = S_ERR;
            else if (mem_gnt)          w_next = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid)     w_next = S_WB;
            else if (w_timeout) w_next = S_ERR;
         end
         S_WB:    w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_type    <= LD_NOP;
         r_rd      <= '0;
         r_cnt     <= '0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
         r_cause   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr <= w_eff;
            r_type <= ld_control;
            r_rd   <= rd;
            r_cnt  <= '0;
            if (!w_type_ok)      r_cause <= CAUSE_ILLEGAL;
            else if (w_misalign) r_cause <= CAUSE_MISALIGN;
         end
         if (w_in_flight) begin
            r_cnt <= r_cnt + 8'd1;
            if (w_next == S_ERR) r_cause <= CAUSE_TIMEOUT;
         end
         // Writes to x0 leave the writeback registers untouched.
         if (w_capture && (r_rd != 5'd0)) begin
            r_wb_rd   <= r_rd;
            r_wb_data <= w_extract;
         end
      end
   end

   assign ld_ready     = (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE);
   assign mem_req      = (r_state == S_REQ);
   assign mem_addr     = {r_addr[XLEN-1:2], 2'b00};
   assign wb_valid     = (r_state == S_WB) && (r_rd != 5'd0);
   assign wb_rd        = r_wb_rd;
   assign wb_data      = r_wb_data;
   assign ld_err       = (r_state == S_ERR);
   assign ld_err_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_load_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_unit_ctrl
// Purpose  : Directed self-checking bench for load_unit_ctrl. Inputs change
//            1 ns after a rising edge and outputs are sampled at that time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_unit_ctrl;

   localparam int XLEN = 32;
   localparam int TO   = 16;

   localparam logic [2:0] LD_NOP = 3'b000;
   localparam logic [2:0] LB     = 3'b001;
   localparam logic [2:0] LH     = 3'b010;
   localparam logic [2:0] LW     = 3'b011;
   localparam logic [2:0] LBU    = 3'b100;
   localparam logic [2:0] LHU    = 3'b101;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ld_valid;
   logic            ld_ready;
   logic [2:0]      ld_control;
   logic [XLEN-1:0] rs1_data;
   logic [11:0]     imm;
   logic [4:0]      rd;
   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ld_err;
   logic [1:0]      ld_err_cause;
   logic            busy;

   int checks = 0;
   int errors = 0;

   load_unit_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_control(ld_control),
      .rs1_data(rs1_data), .imm(imm), .rd(rd),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .ld_err(ld_err), .ld_err_cause(ld_err_cause), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one load for a single accept edge, then withdraw it.
   task automatic issue(input logic [2:0] t, input logic [31:0] base,
                        input logic [11:0] off, input logic [4:0] dst);
      ld_valid = 1'b1; ld_control = t; rs1_data = base; imm = off; rd = dst;
      step();
      ld_valid = 1'b0;
   endtask

   // Zero-wait load: grant and data in the first REQ cycle, checks the WB cycle.
   task automatic zload(input string tag, input logic [2:0] t, input logic [31:0] base,
                        input logic [11:0] off, input logic [4:0] dst,
                        input logic [31:0] data, input logic [31:0] exp);
      issue(t, base, off, dst);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = data;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk({tag, "_wbv"},  32'(wb_valid), 32'd1);
      chk({tag, "_data"}, wb_data, exp);
      step();
   endtask

   // Rejected load: error pulse with the given cause, never a request.
   task automatic eload(input string tag, input logic [2:0] t, input logic [31:0] base,
                        input logic [11:0] off, input logic [1:0] cause);
      issue(t, base, off, 5'd3);
      chk({tag, "_req"},   32'(mem_req), 32'd0);
      chk({tag, "_err"},   32'(ld_err), 32'd1);
      chk({tag, "_cause"}, 32'(ld_err_cause), 32'(cause));
      step();
      chk({tag, "_ready"}, 32'(ld_ready), 32'd1);
      chk({tag, "_hold"},  32'(ld_err_cause), 32'(cause));
   endtask

   initial begin
      int n;
      rst_n = 1'b0; ld_valid = 1'b0; ld_control = LD_NOP; rs1_data = '0; imm = '0;
      rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      step(); step();
      chk("rst_ready", 32'(ld_ready), 32'd1);
      chk("rst_req",   32'(mem_req), 32'd0);
      chk("rst_addr",  mem_addr, 32'h0);
      chk("rst_wbv",   32'(wb_valid), 32'd0);
      chk("rst_wbrd",  32'(wb_rd), 32'd0);
      chk("rst_wbd",   wb_data, 32'h0);
      chk("rst_err",   32'(ld_err), 32'd0);
      chk("rst_cause", 32'(ld_err_cause), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      rst_n = 1'b1;
      step();

      // LW with one wait cycle; a stray rvalid without gnt is ignored first.
      issue(LW, 32'h1000, 12'h004, 5'd5);
      chk("lw_req",   32'(mem_req), 32'd1);
      chk("lw_addr",  mem_addr, 32'h1004);
      chk("lw_ready", 32'(ld_ready), 32'd0);
      chk("lw_busy",  32'(busy), 32'd1);
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      step();
      mem_rvalid = 1'b0;
      chk("lw_req_hold",  32'(mem_req), 32'd1);
      chk("lw_addr_hold", mem_addr, 32'h1004);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("lw_wait_req", 32'(mem_req), 32'd0);
      chk("lw_wait_wbv", 32'(wb_valid), 32'd0);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_rvalid = 1'b0;
      chk("lw_wbv",  32'(wb_valid), 32'd1);
      chk("lw_wbrd", 32'(wb_rd), 32'd5);
      chk("lw_data", wb_data, 32'hDEAD_BEEF);
      step();
      chk("lw_wbv_off", 32'(wb_valid), 32'd0);
      chk("lw_ready2",  32'(ld_ready), 32'd1);
      chk("lw_hold",    wb_data, 32'hDEAD_BEEF);

      // Extraction and extension.
      zload("lb",  LB,  32'h2000, 12'h003, 5'd6, 32'h80FF_0000, 32'hFFFF_FF80);
      zload("lbu", LBU, 32'h2000, 12'h003, 5'd6, 32'h80FF_0000, 32'h0000_0080);
      zload("lb1", LB,  32'h2000, 12'h001, 5'd6, 32'h0000_7F00, 32'h0000_007F);
      zload("lh",  LH,  32'h2000, 12'h002, 5'd7, 32'h8001_0000, 32'hFFFF_8001);
      zload("lhu", LHU, 32'h2000, 12'h002, 5'd7, 32'h8001_0000, 32'h0000_8001);
      zload("lh0", LH,  32'h2000, 12'h000, 5'd7, 32'h1234_F00D, 32'hFFFF_F00D);
      chk("lh0_rd", 32'(wb_rd), 32'd7);

      // Address wrap with negative and positive offsets.
      issue(LW, 32'h0000_0002, 12'hFFE, 5'd8);
      chk("wrap_neg", mem_addr, 32'h0000_0000);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001;
      step(); mem_gnt = 1'b0; mem_rvalid = 1'b0; step();
      issue(LW, 32'hFFFF_FFFC, 12'h008, 5'd8);
      chk("wrap_pos", mem_addr, 32'h0000_0004);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0002;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("wrap_data", wb_data, 32'hA5A5_0002);
      step();

      // Accept-time errors.
      eload("mis_lw", LW,     32'h1000, 12'h002, 2'b01);
      eload("mis_lh", LH,     32'h1000, 12'h001, 2'b01);
      eload("nop",    LD_NOP, 32'h1000, 12'h000, 2'b10);
      eload("unmap",  3'b111, 32'h1001, 12'h000, 2'b10);

      // Stalled memory: granted but never answered.
      issue(LW, 32'h3000, 12'h000, 5'd9);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      n = 1;
      while (!ld_err && n < 40) begin
         step();
         n++;
      end
      chk("to_cycles", 32'(n), 32'(TO));
      chk("to_cause",  32'(ld_err_cause), 32'd3);
      chk("to_wbv",    32'(wb_valid), 32'd0);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      step();
      mem_rvalid = 1'b0;
      chk("late_wbv",   32'(wb_valid), 32'd0);
      chk("late_ready", 32'(ld_ready), 32'd1);
      chk("late_data",  wb_data, 32'hA5A5_0002);

      // rd = 0: the access happens but no writeback strobe.
      issue(LW, 32'h0000_0100, 12'h000, 5'd0);
      chk("x0_req", 32'(mem_req), 32'd1);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("x0_wbv",  32'(wb_valid), 32'd0);
      chk("x0_busy", 32'(busy), 32'd1);
      step();
      chk("x0_ready", 32'(ld_ready), 32'd1);
      chk("x0_hold",  wb_data, 32'hA5A5_0002);

      // Reset while waiting for data; the trailing response is ignored.
      issue(LW, 32'h4000, 12'h000, 5'd10);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mrst_req",   32'(mem_req), 32'd0);
      chk("mrst_ready", 32'(ld_ready), 32'd1);
      chk("mrst_busy",  32'(busy), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
      step();
      mem_rvalid = 1'b0;
      chk("mrst_wbv",  32'(wb_valid), 32'd0);
      chk("mrst_data", wb_data, 32'h0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
